// File: rtl/udp_transmitter.sv
// Builds one ARP reply or one UDP/IPv4 datagram as 32-bit words for a MAC with a 2-byte front pad.
// The payload streams from a synchronous-read word memory, and the address is prefetched one word ahead.
module udp_transmitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_arp,
    input  logic        start_udp,
    input  logic [47:0] my_mac,
    input  logic [47:0] dst_mac,
    input  logic [31:0] ip_my,
    input  logic [31:0] ip_dst,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] identification,
    input  logic [15:0] udp_len,
    output logic [10:0] mem_adr,
    input  logic [31:0] mem_data,
    output logic [31:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_wren,
    output logic [1:0]  tx_mod,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        done,
    output logic        len_err
);
    typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HDR, S_PAY, S_DONE} state_t;
    localparam logic [15:0] MAX_LEN = 16'd1472;

    state_t      state_reg, state_next;
    logic [3:0]  word_idx_reg, word_idx_next;
    logic [10:0] rd_ptr_reg, rd_ptr_next, adr_reg, adr_next;
    logic        is_arp_reg, is_arp_next;
    logic [47:0] my_mac_reg, my_mac_next, dst_mac_reg, dst_mac_next;
    logic [31:0] ip_my_reg, ip_my_next, ip_dst_reg, ip_dst_next;
    logic [15:0] src_port_reg, src_port_next, dst_port_reg, dst_port_next;
    logic [15:0] id_reg, id_next, csum_reg, csum_next;
    logic [10:0] len_reg, len_next;
    logic [31:0] tx_data_reg, tx_data_next;
    logic        tx_sop_reg, tx_sop_next, tx_eop_reg, tx_eop_next, tx_wren_reg, tx_wren_next;
    logic [1:0]  tx_mod_reg, tx_mod_next;
    logic        done_reg, done_next, len_err_reg, len_err_next;

    logic        accept, load_pay, load_last, finish;
    logic [3:0]  hdr_sel;
    logic [31:0] hdr_word, pay_word;
    logic [15:0] ip_total_len, udp_total_len, csum_calc;
    logic [19:0] csum_sum;
    logic [16:0] csum_fold1;
    logic [15:0] csum_fold2;
    logic [10:0] pay_words, load_idx;

    assign accept        = tx_wren_reg & tx_rdy;
    assign ip_total_len  = 16'd28 + {5'd0, len_reg};
    assign udp_total_len = 16'd8 + {5'd0, len_reg};
    assign pay_words     = (len_reg + 11'd3) >> 2;
    assign load_idx      = (state_reg == S_HDR) ? 11'd0 : rd_ptr_reg;
    assign load_last     = ((load_idx + 11'd1) == pay_words);

    // Header words are loaded one ahead: w0 while in CSUM, otherwise the word after the one on the bus.
    assign hdr_sel = (state_reg == S_CSUM) ? 4'd0 : 4'(word_idx_reg + 4'd1);

    always_comb begin
        hdr_word = '0;
        case (hdr_sel)
            4'd0:    hdr_word = {16'h0000, dst_mac_reg[47:32]};
            4'd1:    hdr_word = dst_mac_reg[31:0];
            4'd2:    hdr_word = my_mac_reg[47:16];
            4'd3:    hdr_word = {my_mac_reg[15:0], is_arp_reg ? 16'h0806 : 16'h0800};
            4'd4:    hdr_word = is_arp_reg ? 32'h0001_0800 : {16'h4500, ip_total_len};
            4'd5:    hdr_word = is_arp_reg ? 32'h0604_0002 : {id_reg, 16'h4000};
            4'd6:    hdr_word = is_arp_reg ? my_mac_reg[47:16] : {16'h4011, csum_reg};
            4'd7:    hdr_word = is_arp_reg ? {my_mac_reg[15:0], ip_my_reg[31:16]} : ip_my_reg;
            4'd8:    hdr_word = is_arp_reg ? {ip_my_reg[15:0], dst_mac_reg[47:32]} : ip_dst_reg;
            4'd9:    hdr_word = is_arp_reg ? dst_mac_reg[31:0] : {src_port_reg, dst_port_reg};
            4'd10:   hdr_word = is_arp_reg ? ip_dst_reg : {udp_total_len, 16'h0000};
            default: hdr_word = '0;
        endcase
    end

    // The IP header sum uses a zero checksum field; two end-around folds are enough for ten halfwords.
    always_comb begin
        csum_sum = 20'h04500 + 20'(ip_total_len) + 20'(id_reg) + 20'h04000 + 20'h04011
                 + 20'(ip_my_reg[31:16]) + 20'(ip_my_reg[15:0])
                 + 20'(ip_dst_reg[31:16]) + 20'(ip_dst_reg[15:0]);
        csum_fold1 = {1'b0, csum_sum[15:0]} + {13'd0, csum_sum[19:16]};
        csum_fold2 = csum_fold1[15:0] + {15'd0, csum_fold1[16]};
        csum_calc  = ~csum_fold2;
    end

    always_comb begin
        pay_word = mem_data;
        if (load_last) begin
            case (len_reg[1:0])
                2'd1:    pay_word = {mem_data[31:24], 24'h0};
                2'd2:    pay_word = {mem_data[31:16], 16'h0};
                2'd3:    pay_word = {mem_data[31:8], 8'h0};
                default: pay_word = mem_data;
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;     word_idx_next = word_idx_reg;
        rd_ptr_next   = rd_ptr_reg;    adr_next      = adr_reg;
        is_arp_next   = is_arp_reg;    my_mac_next   = my_mac_reg;
        dst_mac_next  = dst_mac_reg;   ip_my_next    = ip_my_reg;
        ip_dst_next   = ip_dst_reg;    src_port_next = src_port_reg;
        dst_port_next = dst_port_reg;  id_next       = id_reg;
        len_next      = len_reg;       csum_next     = csum_reg;
        tx_data_next  = tx_data_reg;   tx_sop_next   = tx_sop_reg;
        tx_eop_next   = tx_eop_reg;    tx_wren_next  = tx_wren_reg;
        tx_mod_next   = tx_mod_reg;
        done_next     = 1'b0;          len_err_next  = 1'b0;
        load_pay      = 1'b0;          finish        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_arp || (start_udp && udp_len <= MAX_LEN)) begin
                    is_arp_next   = start_arp;
                    my_mac_next   = my_mac;       dst_mac_next  = dst_mac;
                    ip_my_next    = ip_my;        ip_dst_next   = ip_dst;
                    src_port_next = src_port;     dst_port_next = dst_port;
                    id_next       = identification;
                    len_next      = udp_len[10:0];
                    word_idx_next = '0;           rd_ptr_next   = '0;
                    adr_next      = '0;
                    state_next    = S_CSUM;
                end else if (start_udp) begin
                    len_err_next = 1'b1;
                end
            end
            S_CSUM: begin
                csum_next    = csum_calc;
                tx_data_next = hdr_word;
                tx_sop_next  = 1'b1;
                tx_eop_next  = 1'b0;
                tx_mod_next  = 2'd0;
                tx_wren_next = 1'b1;
                state_next   = S_HDR;
            end
            S_HDR: begin
                if (accept) begin
                    if (word_idx_reg != 4'd10) begin
                        word_idx_next = 4'(word_idx_reg + 4'd1);
                        tx_data_next  = hdr_word;
                        tx_sop_next   = 1'b0;
                        tx_eop_next   = (word_idx_reg == 4'd9) && (is_arp_reg || len_reg == 11'd0);
                    end else if (tx_eop_reg) begin
                        finish = 1'b1;
                    end else begin
                        load_pay   = 1'b1;
                        state_next = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (accept) begin
                    if (tx_eop_reg) finish   = 1'b1;
                    else            load_pay = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (load_pay) begin
            tx_data_next = pay_word;
            tx_sop_next  = 1'b0;
            tx_eop_next  = load_last;
            tx_mod_next  = load_last ? 2'(3'd4 - {1'b0, len_reg[1:0]}) : 2'd0;
            rd_ptr_next  = load_idx + 11'd1;
        end
        // The address jumps ahead in the same cycle a word is consumed, so back-to-back accepts see fresh data.
        mem_adr = (load_pay && !load_last) ? (load_idx + 11'd1) : adr_reg;
        adr_next = mem_adr;
        if (finish) begin
            state_next   = S_DONE;
            done_next    = 1'b1;
            tx_data_next = '0;   tx_mod_next = 2'd0;
            tx_sop_next  = 1'b0; tx_eop_next = 1'b0; tx_wren_next = 1'b0;
            adr_next     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;  word_idx_reg <= '0;  rd_ptr_reg   <= '0;
            adr_reg      <= '0;      is_arp_reg   <= 1'b0;
            my_mac_reg   <= '0;      dst_mac_reg  <= '0;  ip_my_reg    <= '0;
            ip_dst_reg   <= '0;      src_port_reg <= '0;  dst_port_reg <= '0;
            id_reg       <= '0;      len_reg      <= '0;  csum_reg     <= '0;
            tx_data_reg  <= '0;      tx_sop_reg   <= 1'b0; tx_eop_reg  <= 1'b0;
            tx_wren_reg  <= 1'b0;    tx_mod_reg   <= 2'd0;
            done_reg     <= 1'b0;    len_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;    word_idx_reg <= word_idx_next; rd_ptr_reg   <= rd_ptr_next;
            adr_reg      <= adr_next;      is_arp_reg   <= is_arp_next;
            my_mac_reg   <= my_mac_next;   dst_mac_reg  <= dst_mac_next;  ip_my_reg    <= ip_my_next;
            ip_dst_reg   <= ip_dst_next;   src_port_reg <= src_port_next; dst_port_reg <= dst_port_next;
            id_reg       <= id_next;       len_reg      <= len_next;      csum_reg     <= csum_next;
            tx_data_reg  <= tx_data_next;  tx_sop_reg   <= tx_sop_next;   tx_eop_reg   <= tx_eop_next;
            tx_wren_reg  <= tx_wren_next;  tx_mod_reg   <= tx_mod_next;
            done_reg     <= done_next;     len_err_reg  <= len_err_next;
        end
    end

    assign tx_data = tx_data_reg;
    assign tx_sop  = tx_sop_reg;
    assign tx_eop  = tx_eop_reg;
    assign tx_wren = tx_wren_reg;
    assign tx_mod  = tx_mod_reg;
    assign busy    = (state_reg != S_IDLE);
    assign done    = done_reg;
    assign len_err = len_err_reg;
endmodule

// File: doc/udp_transmitter.md
UDP_TRANSMITTER -- requirements
Module: udp_transmitter

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start_arp  in  1  one-cycle request: send ARP reply.
REQ-004 start_udp  in  1  one-cycle request: send UDP datagram.
REQ-005 my_mac / dst_mac  in  48 each  own / destination MAC.
REQ-006 ip_my / ip_dst  in  32 each  own / destination IPv4.
REQ-007 src_port / dst_port / identification  in  16 each  UDP ports, IP ID.
REQ-008 udp_len  in  16  payload length in bytes, legal range 0..1472.
REQ-009 mem_adr  out  11  payload word address.
REQ-010 mem_data  in  32  payload word; valid 1 cycle after mem_adr.
REQ-011 tx_data  out  32  frame word; first byte in [31:24].
REQ-012 tx_sop / tx_eop / tx_wren  out  1 each  start, end, word valid.
REQ-013 tx_mod  out  2  invalid trailing bytes in eop word.
REQ-014 tx_rdy  in  1  MAC ready; word transferred when tx_wren=1 and tx_rdy=1.
REQ-015 busy / done / len_err  out  1 each  frame in progress / 1-cycle end pulse / 1-cycle reject pulse.

Function
REQ-016 States: IDLE, CSUM, HDR, PAY, DONE; start inputs sampled only in IDLE, ignored otherwise.
REQ-017 All inputs other than tx_rdy and mem_data latched on the start cycle; later changes do not affect the frame.
REQ-018 Both starts in the same cycle: ARP sent, UDP request dropped.
REQ-019 start_udp with udp_len>1472: len_err pulses the next cycle; state stays IDLE; no frame.
REQ-020 Accepted start in cycle 0: CSUM in cycle 1; tx_wren=1 with tx_sop=1 from cycle 2.
REQ-021 While tx_wren=1 and tx_rdy=0, tx_data/sop/eop/mod/wren held stable.
REQ-022 Frame uses the 2-byte-pad MAC layout. Word0={16'h0000,dst_mac[47:32]}; w1=dst_mac[31:0]; w2=my_mac[47:16]; w3={my_mac[15:0],ethertype}.
REQ-023 ARP (type 0x0806), 11 words, eop on w10, mod 0. w4=0x00010800; w5=0x06040002; w6=my_mac[47:16]; w7={my_mac[15:0],ip_my[31:16]}; w8={ip_my[15:0],dst_mac[47:32]}; w9=dst_mac[31:0]; w10=ip_dst.
REQ-024 UDP (type 0x0800), IP header fields:
  - w4={0x4500,20+8+udp_len}; w5={identification,0x4000}; w6={0x4011,ip_csum}
  - w7=ip_my; w8=ip_dst; w9={src_port,dst_port}; w10={8+udp_len,0x0000}; UDP checksum 0.
REQ-025 ip_csum computed in CSUM: one's-complement of 16-bit end-around-carry sum of the ten IP header halfwords with checksum field=0.
REQ-026 Payload follows w10 in PAY.
  - ceil(udp_len/4) words read from mem_adr=0 upward.
  - mem_adr prefetched so no bubbles occur while tx_rdy=1.
  - mem_adr advances only on an accepted word.
REQ-027 Last payload word: tx_eop=1, tx_mod=(4-udp_len mod 4) mod 4; unused low bytes driven 0.
REQ-028 udp_len=0: eop on w10, mod 0, no memory reads.
REQ-029 Cycle after eop accepted: DONE, done=1, tx_wren=0; next cycle IDLE, busy=0. busy=1 from cycle 1 through DONE.
REQ-030 tx_sop=1 only on w0; tx_eop=1 only on the final word; both 0 whenever tx_wren=0.

Reset
REQ-031 rst=1 forces within the same clock edge:
  - state IDLE
  - tx_wren, tx_sop, tx_eop, busy, done, len_err = 0
  - tx_data=0, tx_mod=0, mem_adr=0
  - latched fields cleared
REQ-032 Reset mid-frame aborts without emitting eop; first start after rst release behaves per REQ-020.

Verification
REQ-033 start_arp, tx_rdy=1, my_mac=001122334455, dst_mac=AABBCCDDEEFF, ip_my=C0A8010A, ip_dst=C0A80101 -> 11 words cycles 2..12; w0=0000AABB, w3=44550806, w5=06040002, w10=C0A80101; eop w10 mod 0; done cycle 13.
REQ-034 start_udp, udp_len=4, id=0001, same IPs, ports 1388/1389, mem[0]=DEADBEEF -> w4=45000020, w6=4011B770, w9=13881389, w10=000C0000, w11=DEADBEEF eop mod 0.
REQ-035 udp_len=5, mem[0]=01020304, mem[1]=05FFFFFF, tx_rdy low 3 cycles on w11 -> w11 held 3 cycles; w12=05000000 eop mod 3; mem_adr 0,1 only.
REQ-036 start_udp udp_len=1473 -> len_err pulse, no tx_wren; simultaneous start_arp+start_udp -> ARP frame only; start during busy ignored.
REQ-037 rst asserted on w6 of UDP frame -> all outputs 0 next cycle, no eop; new start_arp -> correct full frame.
